// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 16-bit left shift/rotate datapath.
// An IDLE/BUSY/DONE FSM accepts one operation per three cycles. The winner is
// granted during BUSY and its result is presented on out, with a done pulse,
// during DONE.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   req0/req1           operation requests
//   in0/in1             16-bit operands
//   shift0/shift1       1 = logical left shift (zero fill), 0 = left rotate
//   shamt0/shamt1       shift/rotate amount 0..15
//   gnt0/gnt1           registered grant pulse, high during BUSY
//   busy                high whenever the FSM is not in IDLE
//   done                one-cycle pulse, out valid while high
//   done_id             requester index of the result on out
//   out                 registered result, held until the next done
//
// Configuration macro: SHIFT_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, req0 wins a tie
//   undefined -> round-robin between the two requesters (default)
module shift_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic        shift0,
  input  logic        shift1,
  input  logic [3:0]  shamt0,
  input  logic [3:0]  shamt1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [15:0] out
);

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          any_req;
  logic          accept;
  logic          win;
  logic          gnt0_nxt;
  logic          gnt1_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic [DW-1:0] op_in;
  logic          op_shift;
  logic [SW-1:0] op_shamt;
  logic          op_id;
  logic [DW-1:0] s1;
  logic [DW-1:0] s2;
  logic [DW-1:0] s4;
  logic [DW-1:0] s8;

  assign any_req = req0 | req1;
  assign accept  = (state == IDLE) && any_req;

  // Winner selection: 0 = requester 0, 1 = requester 1
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic last;

  // On a tie the requester not served last wins
  assign win = (req0 & req1) ? ~last : req1;

  // Last-served pointer; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= win;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers at the next edge
  always_comb begin
    gnt0_nxt = 1'b0;
    gnt1_nxt = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    gnt0_nxt = accept & ~win;
    gnt1_nxt = accept & win;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == BUSY);
  end

  // Operand capture of the winning requester
  always_ff @(posedge clk) begin
    if (rst) begin
      op_in    <= '0;
      op_shift <= 1'b0;
      op_shamt <= '0;
      op_id    <= 1'b0;
    end else if (accept) begin
      op_in    <= win ? in1    : in0;
      op_shift <= win ? shift1 : shift0;
      op_shamt <= win ? shamt1 : shamt0;
      op_id    <= win;
    end
  end

  // Log shifter: vacated bits are zero for shift, wrapped MSBs for rotate
  assign s1 = op_shamt[0] ? {op_in[DW-2:0], op_shift ? 1'b0  : op_in[DW-1]}    : op_in;
  assign s2 = op_shamt[1] ? {s1[DW-3:0],    op_shift ? 2'b00 : s1[DW-1:DW-2]}  : s1;
  assign s4 = op_shamt[2] ? {s2[DW-5:0],    op_shift ? 4'h0  : s2[DW-1:DW-4]}  : s2;
  assign s8 = op_shamt[3] ? {s4[DW-9:0],    op_shift ? 8'h00 : s4[DW-1:DW-8]}  : s4;

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      out     <= '0;
    end else begin
      gnt0 <= gnt0_nxt;
      gnt1 <= gnt1_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
      if (state == BUSY) begin
        out     <= s8;
        done_id <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter. The driver models the
// arbiter at transaction level and queues expected grants/results tagged with
// the cycle they must appear in; an independent monitor pops and compares.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [15:0] in0, in1;
  logic        shift0, shift1;
  logic [3:0]  shamt0, shamt1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [15:0] out;

  shift_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .in0     (in0),
    .in1     (in1),
    .shift0  (shift0),
    .shift1  (shift1),
    .shamt0  (shamt0),
    .shamt1  (shamt1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          id;
    logic [15:0] res;
  } exp_t;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   mstate = M_IDLE;
  exp_t gnt_q[$];
  exp_t done_q[$];
  bit   gnt_log[$];
  bit   exp_busy[int];
`ifndef SHIFT_ARB_FIXED_PRIO_EN
  bit   last = 1'b1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference result from the plain arithmetic definition
  function automatic logic [15:0] ref_op(input logic [15:0] x, input bit sh, input int n);
    int unsigned v;
    int unsigned r;
    v = 32'(x);
    if (sh) r = v << n;
    else    r = (v << n) | (v >> (16 - n));
    return 16'(r);
  endfunction

  function automatic bit pick(input bit r0, input bit r1);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    return r0 ? 1'b0 : 1'b1;
`else
    bit w;
    if (r0 && r1) w = ~last;
    else          w = r1;
    last = w;
    return w;
`endif
  endfunction

  // Model the coming clock edge from the inputs now driven, then move to the
  // next falling edge. The granted requester drops its request afterwards.
  task automatic tick(input bit drop = 1'b1);
    int   nc;
    bit   granted;
    bit   w;
    exp_t e;
    nc = cyc + 1;
    granted = 1'b0;
    w = 1'b0;
    if (rst) begin
      if (mstate == M_BUSY && done_q.size() > 0) void'(done_q.pop_back());
      mstate = M_IDLE;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last = 1'b1;
`endif
    end else begin
      case (mstate)
        M_IDLE: if (req0 || req1) begin
          w = pick(req0, req1);
          e.cyc = nc; e.id = w; e.res = 16'h0;
          gnt_q.push_back(e);
          e.cyc = nc + 1;
          e.res = w ? ref_op(in1, shift1, int'(shamt1)) : ref_op(in0, shift0, int'(shamt0));
          done_q.push_back(e);
          mstate = M_BUSY;
          granted = 1'b1;
        end
        M_BUSY:  mstate = M_DONE;
        default: mstate = M_IDLE;
      endcase
    end
    exp_busy[nc] = (mstate != M_IDLE);
    @(negedge clk);
    if (granted && drop) begin
      if (w) req1 = 1'b0;
      else   req0 = 1'b0;
    end
  endtask

  task automatic run_op(input bit id, input logic [15:0] x, input bit sh,
                        input logic [3:0] n, input logic [15:0] want, input string name);
    if (id) begin req1 = 1'b1; in1 = x; shift1 = sh; shamt1 = n; end
    else    begin req0 = 1'b1; in0 = x; shift0 = sh; shamt0 = n; end
    tick();
    // Operands change right after grant; the result must not follow them
    if (id) begin in1 = ~x; shift1 = ~sh; shamt1 = ~n; end
    else    begin in0 = ~x; shift0 = ~sh; shamt0 = ~n; end
    tick();
    tick();
    chk({name, "_out"}, 32'(out), 32'(want));
    chk({name, "_id"}, 32'(done_id), 32'(id));
  endtask

  // Monitor: compares every presented grant and result with the queues
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_busy.exists(cyc)) chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        gnt_log.push_back(gnt1);
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        if (gnt_q.size() == 0) begin
          n_chk++;
          $display("FAIL gnt_unexpected: got gnt0=%b gnt1=%b want none (cycle %0d)", gnt0, gnt1, cyc);
        end else begin
          e = gnt_q.pop_front();
          chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_id", 32'(gnt1), 32'(e.id));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done=1 out=%h want no done (cycle %0d)", out, cyc);
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_id", 32'(done_id), 32'(e.id));
          chk("done_out", 32'(out), 32'(e.res));
        end
      end
    end
  end

  // Driver
  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    in0 = '0; in1 = '0;
    shift0 = 1'b0; shift1 = 1'b0;
    shamt0 = '0; shamt1 = '0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_out", 32'(out), 32'h0);
    rst = 1'b0;
    tick();

    run_op(1'b0, 16'h8001, 1'b0, 4'd1,  16'h0003, "rot1");
    run_op(1'b1, 16'h00FF, 1'b1, 4'd4,  16'h0FF0, "shl4");
    run_op(1'b1, 16'hFFFF, 1'b1, 4'd15, 16'h8000, "shl15");
    run_op(1'b0, 16'hF000, 1'b0, 4'd8,  16'h00F0, "rot8");
    run_op(1'b0, 16'hF000, 1'b0, 4'd0,  16'hF000, "rot0");
    run_op(1'b1, 16'hA5C3, 1'b1, 4'd0,  16'hA5C3, "shl0");

    // Both requests held high from reset
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    in0 = 16'h1111; in1 = 16'h2222;
    tick();
    rst = 1'b0;
    gnt_log.delete();
    repeat (9) tick(1'b0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    if (gnt_log.size() < 3) begin
      n_chk++;
      $display("FAIL hold_grants: got %0d grants want 3", gnt_log.size());
    end else begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      chk("hold_seq", 32'({gnt_log[0], gnt_log[1], gnt_log[2]}), 32'b000);
`else
      chk("hold_seq", 32'({gnt_log[0], gnt_log[1], gnt_log[2]}), 32'b010);
`endif
    end

    // Reset during BUSY aborts the operation
    req0 = 1'b1; in0 = 16'h1234; shift0 = 1'b0; shamt0 = 4'd3;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_out", 32'(out), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    gnt_log.delete();
    req0 = 1'b1; req1 = 1'b1;
    repeat (6) tick();
    if (gnt_log.size() < 2) begin
      n_chk++;
      $display("FAIL abort_tie: got %0d grants want 2", gnt_log.size());
    end else begin
      chk("abort_tie_first", 32'(gnt_log[0]), 32'd0);
      chk("abort_tie_second", 32'(gnt_log[1]), 32'd1);
    end

    // Randomized traffic; operands change every cycle
    repeat (1500) begin
      if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
      if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
      in0 = 16'($urandom); in1 = 16'($urandom);
      shift0 = 1'($urandom); shift1 = 1'($urandom);
      shamt0 = 4'($urandom); shamt1 = 4'($urandom);
      tick();
    end

    req0 = 1'b0; req1 = 1'b0;
    repeat (5) tick();
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
